// File: rtl/pipeline_ex_stage5.sv
// Execute stage: ALU, branch/jump resolution with one-shot PC redirect, iterative shift-add multiply.
// Latency: 1 edge for ALU/jump/branch; MUL_ITER+2 edges for MUL when not stalled.
// Backpressure: stall holds the EX register; busy_EX holds IF..IDR while a multiply iterates.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   stall, flush             MEM-stage hold of the EX register / kill of the instruction at EX input
//   *_IDR                    operands and controls latched by the IDR stage
//   *_EX                     EX pipeline register presented to the MEM stage
//   redirect_valid/_pc       combinational PC redirect for taken branches and jumps
//   busy_EX                  combinational hold request while a multiply is in flight
module pipeline_ex_stage5 #(
  parameter int MUL_ITER = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [63:0] pc_IDR,
  input  logic [63:0] reg_data1_IDR,
  input  logic [63:0] reg_data2_IDR,
  input  logic [4:0]  rd_IDR,
  input  logic [63:0] imm_IDR,
  input  logic        rf_wr_en_IDR,
  input  logic        do_jump_IDR,
  input  logic        is_branch_IDR,
  input  logic        alu_a_sel_IDR,
  input  logic        alu_b_sel_IDR,
  input  logic [3:0]  alu_ctrl_IDR,
  input  logic [2:0]  BrType_IDR,
  input  logic [1:0]  rf_wr_sel_IDR,
  input  logic [2:0]  dm_rd_ctrl_IDR,
  input  logic [2:0]  dm_wr_ctrl_IDR,
  output logic [63:0] alu_result_EX,
  output logic [63:0] rs2_data_EX,
  output logic [4:0]  rd_EX,
  output logic        rf_wr_en_EX,
  output logic [1:0]  rf_wr_sel_EX,
  output logic [2:0]  dm_rd_ctrl_EX,
  output logic [2:0]  dm_wr_ctrl_EX,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy_EX
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

  localparam int              CNT_W    = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);
  localparam logic [3:0]      OP_MUL   = 4'd15;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      mcand, mplier, acc;

  logic [63:0] op_a, op_b, alu_out;
  logic [5:0]  shamt;
  logic        is_mul, br_taken;
  logic        mul_start, mul_step;
  logic        ld_bubble, ld_alu, ld_mul;

  assign op_a   = alu_a_sel_IDR ? pc_IDR : reg_data1_IDR;
  assign op_b   = alu_b_sel_IDR ? imm_IDR : reg_data2_IDR;
  assign shamt  = op_b[5:0];
  assign is_mul = (alu_ctrl_IDR == OP_MUL);

  always_comb begin
    alu_out = '0;
    case (alu_ctrl_IDR)
      4'd0:  alu_out = op_a + op_b;
      4'd1:  alu_out = op_a - op_b;
      4'd2:  alu_out = op_a << shamt;
      4'd3:  alu_out = {63'd0, $signed(op_a) < $signed(op_b)};
      4'd4:  alu_out = {63'd0, op_a < op_b};
      4'd5:  alu_out = op_a ^ op_b;
      4'd6:  alu_out = op_a >> shamt;
      4'd7:  alu_out = $signed(op_a) >>> shamt;
      4'd8:  alu_out = op_a | op_b;
      4'd9:  alu_out = op_a & op_b;
      4'd10: alu_out = op_b;
      default: alu_out = '0;
    endcase
  end

  // Branch compare always uses the register operands, never the ALU muxes.
  always_comb begin
    br_taken = 1'b0;
    case (BrType_IDR)
      3'b000: br_taken = (reg_data1_IDR == reg_data2_IDR);
      3'b001: br_taken = (reg_data1_IDR != reg_data2_IDR);
      3'b100: br_taken = ($signed(reg_data1_IDR) <  $signed(reg_data2_IDR));
      3'b101: br_taken = ($signed(reg_data1_IDR) >= $signed(reg_data2_IDR));
      3'b110: br_taken = (reg_data1_IDR <  reg_data2_IDR);
      3'b111: br_taken = (reg_data1_IDR >= reg_data2_IDR);
      default: br_taken = 1'b0;
    endcase
    br_taken = br_taken & is_branch_IDR;
  end

  assign redirect_pc = do_jump_IDR ? ((op_a + op_b) & ~64'h1) : (pc_IDR + imm_IDR);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    busy_EX        = 1'b0;
    redirect_valid = 1'b0;
    mul_start      = 1'b0;
    mul_step       = 1'b0;
    ld_bubble      = 1'b0;
    ld_alu         = 1'b0;
    ld_mul         = 1'b0;
    if (reset) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (flush) begin
      // Abort everything; the EX register only takes the bubble when MEM can accept it.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      ld_bubble = ~stall;
    end else begin
      case (state)
        IDLE: begin
          if (!stall) begin
            redirect_valid = do_jump_IDR | br_taken;
            if (is_mul) begin
              busy_EX   = 1'b1;
              mul_start = 1'b1;
              ld_bubble = 1'b1;
              state_nxt = MUL;
              cnt_nxt   = '0;
            end else begin
              ld_alu = 1'b1;
            end
          end
        end
        MUL: begin
          // Iteration continues under stall; only the EX register is held.
          busy_EX   = 1'b1;
          mul_step  = 1'b1;
          ld_bubble = ~stall;
          if (cnt == CNT_LAST) state_nxt = DONE;
          else                 cnt_nxt   = cnt + CNT_W'(1);
        end
        DONE: begin
          if (!stall) begin
            ld_mul    = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (mul_start) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
      end else if (mul_step) begin
        // One multiplier bit per cycle, LSB first; only the low 64 bits are kept.
        acc    <= acc + (mplier[0] ? mcand : 64'd0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ld_bubble) begin
      alu_result_EX <= '0;
      rs2_data_EX   <= '0;
      rd_EX         <= '0;
      rf_wr_en_EX   <= 1'b0;
      rf_wr_sel_EX  <= '0;
      dm_rd_ctrl_EX <= '0;
      dm_wr_ctrl_EX <= '0;
    end else if (ld_alu || ld_mul) begin
      alu_result_EX <= ld_mul ? acc : (do_jump_IDR ? pc_IDR + 64'd4 : alu_out);
      rs2_data_EX   <= reg_data2_IDR;
      rd_EX         <= rd_IDR;
      rf_wr_en_EX   <= rf_wr_en_IDR;
      rf_wr_sel_EX  <= rf_wr_sel_IDR;
      dm_rd_ctrl_EX <= dm_rd_ctrl_IDR;
      dm_wr_ctrl_EX <= dm_wr_ctrl_IDR;
    end
  end

endmodule

// File: tb/tb_pipeline_ex_stage5.sv
`timescale 1ns/1ps
module tb_pipeline_ex_stage5;
  localparam int MUL_ITER = 64;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [63:0] pc_IDR, reg_data1_IDR, reg_data2_IDR, imm_IDR;
  logic [4:0]  rd_IDR;
  logic        rf_wr_en_IDR, do_jump_IDR, is_branch_IDR, alu_a_sel_IDR, alu_b_sel_IDR;
  logic [3:0]  alu_ctrl_IDR;
  logic [2:0]  BrType_IDR, dm_rd_ctrl_IDR, dm_wr_ctrl_IDR;
  logic [1:0]  rf_wr_sel_IDR;
  logic [63:0] alu_result_EX, rs2_data_EX, redirect_pc;
  logic [4:0]  rd_EX;
  logic        rf_wr_en_EX, redirect_valid, busy_EX;
  logic [1:0]  rf_wr_sel_EX;
  logic [2:0]  dm_rd_ctrl_EX, dm_wr_ctrl_EX;

  always #5 clk = ~clk;

  pipeline_ex_stage5 #(.MUL_ITER(MUL_ITER)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .pc_IDR(pc_IDR), .reg_data1_IDR(reg_data1_IDR), .reg_data2_IDR(reg_data2_IDR),
    .rd_IDR(rd_IDR), .imm_IDR(imm_IDR), .rf_wr_en_IDR(rf_wr_en_IDR),
    .do_jump_IDR(do_jump_IDR), .is_branch_IDR(is_branch_IDR),
    .alu_a_sel_IDR(alu_a_sel_IDR), .alu_b_sel_IDR(alu_b_sel_IDR),
    .alu_ctrl_IDR(alu_ctrl_IDR), .BrType_IDR(BrType_IDR), .rf_wr_sel_IDR(rf_wr_sel_IDR),
    .dm_rd_ctrl_IDR(dm_rd_ctrl_IDR), .dm_wr_ctrl_IDR(dm_wr_ctrl_IDR),
    .alu_result_EX(alu_result_EX), .rs2_data_EX(rs2_data_EX), .rd_EX(rd_EX),
    .rf_wr_en_EX(rf_wr_en_EX), .rf_wr_sel_EX(rf_wr_sel_EX),
    .dm_rd_ctrl_EX(dm_rd_ctrl_EX), .dm_wr_ctrl_EX(dm_wr_ctrl_EX),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy_EX(busy_EX)
  );

  typedef struct {
    logic [63:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        wen, jmp, br, asel, bsel;
    logic [3:0]  op;
    logic [2:0]  bt, rdc, wrc;
    logic [1:0]  wsel;
  } instr_t;

  typedef struct {
    logic [63:0] alu, rs2;
    logic [4:0]  rd;
    logic        wen;
    logic [1:0]  wsel;
    logic [2:0]  rdc, wrc;
  } exreg_t;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  // Reference model: the EX register contents, and the life of an accepted multiply
  // measured in edges since acceptance (1..MUL_ITER iterating, MUL_ITER+1 waiting to retire).
  exreg_t      m_ex;
  bit          m_active   = 0;
  int          m_age      = 0;
  logic [63:0] m_prod     = '0;
  bit          m_consumed = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i);
    pc_IDR = i.pc; reg_data1_IDR = i.rs1; reg_data2_IDR = i.rs2; imm_IDR = i.imm;
    rd_IDR = i.rd; rf_wr_en_IDR = i.wen; do_jump_IDR = i.jmp; is_branch_IDR = i.br;
    alu_a_sel_IDR = i.asel; alu_b_sel_IDR = i.bsel; alu_ctrl_IDR = i.op; BrType_IDR = i.bt;
    rf_wr_sel_IDR = i.wsel; dm_rd_ctrl_IDR = i.rdc; dm_wr_ctrl_IDR = i.wrc;
  endtask

  function automatic instr_t alu_i(input logic [3:0] op, input logic [63:0] rs1,
                                   input logic [63:0] rs2, input logic [4:0] rd);
    instr_t i;
    i.pc = 64'h40; i.rs1 = rs1; i.rs2 = rs2; i.imm = '0; i.rd = rd; i.wen = (rd != 0);
    i.jmp = 0; i.br = 0; i.asel = 0; i.bsel = 0; i.op = op; i.bt = 3'b010;
    i.rdc = 3'd0; i.wrc = 3'd0; i.wsel = 2'd1;
    return i;
  endfunction

  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 8)) - 64'd4;
    return {$urandom, $urandom};
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    i.pc = {$urandom, $urandom}; i.rs1 = rnd64();
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : rnd64();
    i.imm = rnd64(); i.rd = 5'($urandom); i.wen = 1'($urandom);
    i.wsel = 2'($urandom); i.rdc = 3'($urandom); i.wrc = 3'($urandom);
    k = $urandom_range(0, 11);
    i.op = (k == 11) ? 4'd15 : 4'(k);
    i.asel = 1'($urandom); i.bsel = 1'($urandom); i.bt = 3'($urandom);
    i.jmp = ($urandom_range(0, 7) == 0);
    i.br  = !i.jmp && ($urandom_range(0, 3) == 0);
    if (i.jmp) i.op = 4'd0;
    return i;
  endfunction

  function automatic logic [63:0] cur_a(); return alu_a_sel_IDR ? pc_IDR : reg_data1_IDR; endfunction
  function automatic logic [63:0] cur_b(); return alu_b_sel_IDR ? imm_IDR : reg_data2_IDR; endfunction

  function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd4:  return (a < b) ? 64'd1 : 64'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return $signed(a) >>> sh;
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit taken_f();
    logic [63:0] x, y;
    x = reg_data1_IDR; y = reg_data2_IDR;
    if (!is_branch_IDR) return 0;
    case (BrType_IDR)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) <  $signed(y);
      3'b101: return $signed(x) >= $signed(y);
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 0;
    endcase
  endfunction

  function automatic exreg_t ex_of(input logic [63:0] res);
    exreg_t e;
    e.alu = res; e.rs2 = reg_data2_IDR; e.rd = rd_IDR; e.wen = rf_wr_en_IDR;
    e.wsel = rf_wr_sel_IDR; e.rdc = dm_rd_ctrl_IDR; e.wrc = dm_wr_ctrl_IDR;
    return e;
  endfunction

  function automatic exreg_t ex_zero();
    exreg_t e;
    e.alu = '0; e.rs2 = '0; e.rd = '0; e.wen = 0; e.wsel = '0; e.rdc = '0; e.wrc = '0;
    return e;
  endfunction

  // Model update on each edge from the input values that were stable before it.
  bit m_idle, m_is_mul;
  always @(posedge clk) begin
    m_idle     = !m_active;
    m_is_mul   = (alu_ctrl_IDR == 4'd15);
    m_consumed = 0;
    if (reset) begin
      m_ex = ex_zero(); m_active = 0; m_age = 0; m_consumed = 1;
    end else begin
      if (!stall) begin
        if (flush)                  m_ex = ex_zero();
        else if (m_idle)            m_ex = m_is_mul ? ex_zero()
                                         : ex_of(do_jump_IDR ? pc_IDR + 64'd4 : alu_f(alu_ctrl_IDR, cur_a(), cur_b()));
        else if (m_age <= MUL_ITER) m_ex = ex_zero();
        else                        m_ex = ex_of(m_prod);
      end
      if (flush) begin
        m_active = 0; m_consumed = 1;
      end else if (m_idle) begin
        if (!stall) begin
          if (m_is_mul) begin m_active = 1; m_age = 1; m_prod = cur_a() * cur_b(); end
          else m_consumed = 1;
        end
      end else if (m_age <= MUL_ITER) begin
        m_age++;
      end else if (!stall) begin
        m_active = 0; m_consumed = 1;
      end
    end
  end

  // Compare every cycle at the falling edge.
  bit          e_busy, e_rv;
  logic [63:0] e_rpc;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = !reset && !flush &&
               ((!m_active && alu_ctrl_IDR == 4'd15 && !stall) || (m_active && m_age <= MUL_ITER));
      e_rv   = !reset && !flush && !stall && !m_active && (do_jump_IDR || taken_f());
      e_rpc  = do_jump_IDR ? ((cur_a() + cur_b()) & ~64'h1) : pc_IDR + imm_IDR;
      chk("cyc_busy", busy_EX, e_busy);
      chk("cyc_redirect_valid", redirect_valid, e_rv);
      if (e_rv) chk("cyc_redirect_pc", redirect_pc, e_rpc);
      chk("cyc_alu_result", alu_result_EX, m_ex.alu);
      chk("cyc_rs2_data", rs2_data_EX, m_ex.rs2);
      chk("cyc_ctrl", {rd_EX, rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX},
                      {m_ex.rd, m_ex.wen, m_ex.wsel, m_ex.rdc, m_ex.wrc});
    end
  end

  instr_t t;
  instr_t nop_i;
  int     edges, busyc;
  bit     done;

  initial begin
    nop_i = alu_i(4'd0, 64'd0, 64'd0, 5'd0);
    reset = 1; stall = 0; flush = 0;
    drive(nop_i);
    tick; tick;
    chk_en = 1;

    // Reset cycle: a jump and a multiply presented under reset must do nothing.
    t = alu_i(4'd0, 64'h10, 64'd0, 5'd1); t.jmp = 1; t.bsel = 1; t.imm = 64'h8;
    drive(t); #1 chk("rst_redirect_valid", redirect_valid, 0);
    drive(alu_i(4'd15, 64'd3, 64'd5, 5'd2)); #1 chk("rst_busy", busy_EX, 0);
    chk("rst_alu_result", alu_result_EX, 0);
    chk("rst_rf_wr_en", rf_wr_en_EX, 0);
    tick;
    reset = 0;

    // ADD 5+7
    t = alu_i(4'd0, 64'd5, 64'd7, 5'd7); t.wsel = 2'd2; t.rdc = 3'd3;
    drive(t); tick;
    chk("add_result", alu_result_EX, 64'd12);
    chk("add_model", m_ex.alu, 64'd12);
    chk("add_rd", rd_EX, 5'd7);
    chk("add_ctrl", {rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX}, {1'b1, 2'd2, 3'd3});
    chk("add_rs2", rs2_data_EX, 64'd7);

    // SUB 5-7
    drive(alu_i(4'd1, 64'd5, 64'd7, 5'd8)); tick;
    chk("sub_result", alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFE);

    // BLT / BLTU with rs1=-1, rs2=1
    t = alu_i(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0);
    t.br = 1; t.bt = 3'b100; t.pc = 64'h100; t.imm = 64'h20;
    drive(t); #1;
    chk("blt_valid", redirect_valid, 1);
    chk("blt_pc", redirect_pc, 64'h120);
    tick;
    t.bt = 3'b110;
    drive(t); #1 chk("bltu_valid", redirect_valid, 0);
    tick;

    // JALR rs1=0x1001 imm=4 pc=0x200
    t = alu_i(4'd0, 64'h1001, 64'd0, 5'd1);
    t.jmp = 1; t.bsel = 1; t.imm = 64'd4; t.pc = 64'h200;
    drive(t); #1;
    chk("jalr_valid", redirect_valid, 1);
    chk("jalr_pc", redirect_pc, 64'h1004);
    tick;
    chk("jalr_link", alu_result_EX, 64'h204);

    // MUL 3 * -2: 65 busy cycles, product on the 66th edge
    drive(alu_i(4'd15, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd9));
    edges = 0; busyc = 0; done = 0;
    while (!done && edges < 100) begin
      #1;
      if (busy_EX) busyc++;
      tick;
      edges++;
      if (rf_wr_en_EX) done = 1;
    end
    drive(nop_i);
    chk("mul_edges", edges, 66);
    chk("mul_busy_cycles", busyc, 65);
    chk("mul_result", alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mul_rd", rd_EX, 5'd9);

    // MUL again, stalled 3 cycles while waiting to retire
    drive(alu_i(4'd15, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 5'd10));
    repeat (65) tick;
    #1 chk("mul_done_busy", busy_EX, 0);
    stall = 1;
    repeat (3) tick;
    chk("mul_stall_hold", rf_wr_en_EX, 0);
    stall = 0;
    tick;
    drive(nop_i);
    chk("mul_stall_result", alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mul_stall_wen", rf_wr_en_EX, 1);

    // Flush a multiply after 10 cycles, then ADD completes in one edge
    drive(alu_i(4'd15, 64'd11, 64'd13, 5'd11));
    repeat (10) tick;
    flush = 1;
    #1 chk("flush_busy", busy_EX, 0);
    tick;
    flush = 0;
    drive(alu_i(4'd0, 64'd100, 64'd23, 5'd3));
    #1 chk("flush_idle_busy", busy_EX, 0);
    chk("flush_no_write", rf_wr_en_EX, 0);
    tick;
    chk("flush_add_result", alu_result_EX, 64'd123);
    chk("flush_add_wen", rf_wr_en_EX, 1);

    // Reset in the middle of a multiply
    drive(alu_i(4'd15, 64'd7, 64'd9, 5'd12));
    repeat (20) tick;
    #1 chk("mid_mul_busy", busy_EX, 1);
    reset = 1;
    #1 chk("mid_rst_busy", busy_EX, 0);
    tick;
    chk("mid_rst_alu", alu_result_EX, 0);
    chk("mid_rst_ctrl", {rd_EX, rf_wr_en_EX}, 0);
    reset = 0;
    drive(nop_i);
    #1 chk("mid_rst_fsm_idle", busy_EX, 0);
    tick;

    // Randomized traffic; a new instruction appears only once the previous one has left IDR.
    for (int c = 0; c < 4000; c++) begin
      if (m_consumed) drive(rand_instr());
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 999) == 0);
      tick;
    end
    stall = 0; flush = 0; reset = 0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
